// File: rtl/dmem_pkg.sv
// Shared encodings and constants for the data-memory arbiter.
package dmem_pkg;
   localparam int         ADDR_W_DEF   = 12;
   localparam int         BYTE_OFF_DEF = 2;
   localparam logic [3:0] BE_FULL      = 4'hF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RMW_RD = 2'd1,
      RMW_WR = 2'd2
   } state_t;
endpackage

// File: rtl/dmem_be_merge.sv
// Byte-lane merge for partial stores: lane i takes wdata when be[i] is set, else keeps the old word.
module dmem_be_merge (
   input  logic [31:0] i_old_word,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_be,
   output logic [31:0] o_merged
);
   always_comb begin
      o_merged = i_old_word;
      for (int i = 0; i < 4; i++) begin
         if (i_be[i]) o_merged[8*i +: 8] = i_wdata[8*i +: 8];
      end
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for DATA_MEM with read-modify-write for partial stores.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed r0 priority.
//
//   state  | meaning
//   IDLE   | arbitrate; loads, full stores and be=0 stores complete here
//   RMW_RD | read the old word at the captured index
//   RMW_WR | write the merged word, respond next cycle
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int BYTE_OFF = BYTE_OFF_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic        r0_we,
   input  logic [31:0] r0_addr,
   input  logic [31:0] r0_wdata,
   input  logic [3:0]  r0_be,
   output logic        r0_rsp_valid,
   output logic [31:0] r0_rdata,
   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic        r1_we,
   input  logic [31:0] r1_addr,
   input  logic [31:0] r1_wdata,
   input  logic [3:0]  r1_be,
   output logic        r1_rsp_valid,
   output logic [31:0] r1_rdata,
   output logic        mem_write_en,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_write_data,
   output logic [31:0] mem_read_addr,
   input  logic [31:0] mem_read_data
);
   state_t              r_state, w_state_nxt;
   logic                w_idle, w_gnt0, w_gnt1, w_gnt;
   logic [ADDR_W-1:0]   w_idx0, w_idx1, w_sel_idx, r_idx;
   logic                w_sel_we;
   logic [31:0]         w_sel_wdata, w_merged;
   logic [3:0]          w_sel_be;
   logic                r_id;
   logic [31:0]         r_wdata, r_old, r_rdata0, r_rdata1;
   logic [3:0]          r_be;
   logic [1:0]          r_rsp;
   logic                w_unused;

   assign w_idx0   = r0_addr[BYTE_OFF+ADDR_W-1:BYTE_OFF];
   assign w_idx1   = r1_addr[BYTE_OFF+ADDR_W-1:BYTE_OFF];
   assign w_unused = ^{r0_addr[31:BYTE_OFF+ADDR_W], r0_addr[BYTE_OFF-1:0],
                       r1_addr[31:BYTE_OFF+ADDR_W], r1_addr[BYTE_OFF-1:0]};

   // Grants are held off while reset is asserted so every output reads 0 in reset.
   assign w_idle = (r_state == IDLE) && rst_n;

`ifdef DMEM_ARB_RR_EN
   logic r_prio;  // 0: r0 wins a tie, 1: r1 wins a tie

   always_comb begin
      if (!r_prio) begin
         w_gnt0 = w_idle && r0_valid;
         w_gnt1 = w_idle && r1_valid && !r0_valid;
      end else begin
         w_gnt1 = w_idle && r1_valid;
         w_gnt0 = w_idle && r0_valid && !r1_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_prio <= 1'b0;
      else if (w_gnt) r_prio <= ~w_gnt1;
   end
`else
   assign w_gnt0 = w_idle && r0_valid;
   assign w_gnt1 = w_idle && r1_valid && !r0_valid;
`endif

   assign w_gnt       = w_gnt0 || w_gnt1;
   assign r0_ready    = w_gnt0;
   assign r1_ready    = w_gnt1;
   assign w_sel_idx   = w_gnt1 ? w_idx1   : w_idx0;
   assign w_sel_we    = w_gnt1 ? r1_we    : r0_we;
   assign w_sel_wdata = w_gnt1 ? r1_wdata : r0_wdata;
   assign w_sel_be    = w_gnt1 ? r1_be    : r0_be;

   dmem_be_merge u_merge (
      .i_old_word (r_old),
      .i_wdata    (r_wdata),
      .i_be       (r_be),
      .o_merged   (w_merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      mem_write_en   = 1'b0;
      mem_write_addr = '0;
      mem_write_data = '0;
      mem_read_addr  = '0;
      case (r_state)
         IDLE: begin
            if (w_gnt) begin
               mem_read_addr = 32'(w_sel_idx);
               if (w_sel_we && w_sel_be == BE_FULL) begin
                  mem_write_en   = 1'b1;
                  mem_write_addr = 32'(w_sel_idx);
                  mem_write_data = w_sel_wdata;
               end else if (w_sel_we && w_sel_be != 4'h0) begin
                  w_state_nxt = RMW_RD;
               end
            end
         end
         RMW_RD: begin
            mem_read_addr = 32'(r_idx);
            w_state_nxt   = RMW_WR;
         end
         RMW_WR: begin
            mem_write_en   = 1'b1;
            mem_write_addr = 32'(r_idx);
            mem_write_data = w_merged;
            w_state_nxt    = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp    <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
         r_id     <= 1'b0;
         r_idx    <= '0;
         r_wdata  <= '0;
         r_be     <= '0;
         r_old    <= '0;
      end else begin
         r_rsp <= '0;
         if (r_state == RMW_RD) r_old <= mem_read_data;
         if (r_state == RMW_WR) r_rsp[r_id] <= 1'b1;
         if (w_gnt) begin
            if (!w_sel_we) begin
               r_rsp[w_gnt1] <= 1'b1;
               if (w_gnt1) r_rdata1 <= mem_read_data;
               else        r_rdata0 <= mem_read_data;
            end else if (w_sel_be == BE_FULL || w_sel_be == 4'h0) begin
               r_rsp[w_gnt1] <= 1'b1;
            end else begin
               r_id    <= w_gnt1;
               r_idx   <= w_sel_idx;
               r_wdata <= w_sel_wdata;
               r_be    <= w_sel_be;
            end
         end
      end
   end

   assign r0_rsp_valid = r_rsp[0];
   assign r1_rsp_valid = r_rsp[1];
   assign r0_rdata     = r_rdata0;
   assign r1_rdata     = r_rdata1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural DATA_MEM model.
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_valid, r0_ready, r0_we, r0_rsp_valid;
   logic [31:0] r0_addr, r0_wdata, r0_rdata;
   logic [3:0]  r0_be;
   logic        r1_valid, r1_ready, r1_we, r1_rsp_valid;
   logic [31:0] r1_addr, r1_wdata, r1_rdata;
   logic [3:0]  r1_be;
   logic        mem_write_en;
   logic [31:0] mem_write_addr, mem_write_data, mem_read_addr, mem_read_data;

   logic [31:0] mem [0:4095];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          wr_cnt  = 0;
   int          wr_snap;

   dmem_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .r0_valid       (r0_valid),
      .r0_ready       (r0_ready),
      .r0_we          (r0_we),
      .r0_addr        (r0_addr),
      .r0_wdata       (r0_wdata),
      .r0_be          (r0_be),
      .r0_rsp_valid   (r0_rsp_valid),
      .r0_rdata       (r0_rdata),
      .r1_valid       (r1_valid),
      .r1_ready       (r1_ready),
      .r1_we          (r1_we),
      .r1_addr        (r1_addr),
      .r1_wdata       (r1_wdata),
      .r1_be          (r1_be),
      .r1_rsp_valid   (r1_rsp_valid),
      .r1_rdata       (r1_rdata),
      .mem_write_en   (mem_write_en),
      .mem_write_addr (mem_write_addr),
      .mem_write_data (mem_write_data),
      .mem_read_addr  (mem_read_addr),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write_en) begin
         mem[mem_write_addr[11:0]] <= mem_write_data;
         wr_cnt <= wr_cnt + 1;
      end
   end
   assign mem_read_data = mem[mem_read_addr[11:0]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      @(negedge clk);
   endtask

   task automatic idle_all;
      r0_valid = 1'b0;
      r1_valid = 1'b0;
   endtask

   task automatic req0(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      r0_valid = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wd; r0_be = be;
   endtask

   task automatic req1(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      r1_valid = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wd; r1_be = be;
   endtask

   task automatic store0(input logic [31:0] addr, input logic [31:0] wd);
      step; req0(1'b1, addr, wd, 4'hF);
      step; idle_all;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic exp0;
      rst_n = 1'b0;
      idle_all;
      r0_we = 1'b0; r0_addr = 32'h10; r0_wdata = '0; r0_be = '0;
      r1_we = 1'b0; r1_addr = '0;     r1_wdata = '0; r1_be = '0;
      r0_valid = 1'b1;
      repeat (3) @(posedge clk);
      settle;
      chk("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
      chk("rst_r1_ready", {31'd0, r1_ready}, 32'd0);
      chk("rst_r0_rsp",   {31'd0, r0_rsp_valid}, 32'd0);
      chk("rst_r1_rsp",   {31'd0, r1_rsp_valid}, 32'd0);
      chk("rst_we",       {31'd0, mem_write_en}, 32'd0);
      chk("rst_r0_rdata", r0_rdata, 32'd0);
      chk("rst_r1_rdata", r1_rdata, 32'd0);
      chk("rst_raddr",    mem_read_addr, 32'd0);
      chk("rst_waddr",    mem_write_addr, 32'd0);
      chk("rst_wdata",    mem_write_data, 32'd0);
      idle_all;
      rst_n = 1'b1;

      // full store then load of the same address on the next cycle
      step; req0(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      settle;
      chk("st_ready", {31'd0, r0_ready}, 32'd1);
      chk("st_we",    {31'd0, mem_write_en}, 32'd1);
      chk("st_waddr", mem_write_addr, 32'd4);
      chk("st_wdata", mem_write_data, 32'hDEADBEEF);
      step; req0(1'b0, 32'h10, 32'h0, 4'h0);
      settle;
      chk("st_rsp",        {31'd0, r0_rsp_valid}, 32'd1);
      chk("st_rdata_keep", r0_rdata, 32'd0);
      chk("ld_raddr",      mem_read_addr, 32'd4);
      chk("ld_we",         {31'd0, mem_write_en}, 32'd0);
      step; idle_all;
      settle;
      chk("ld_rsp",   {31'd0, r0_rsp_valid}, 32'd1);
      chk("ld_rdata", r0_rdata, 32'hDEADBEEF);
      step;
      settle;
      chk("ld_rsp_once", {31'd0, r0_rsp_valid}, 32'd0);

      // byte store over DEADBEEF, with a load held waiting behind it
      step; req0(1'b1, 32'h10, 32'h000000AB, 4'b0001);
      settle;
      chk("pst_ready", {31'd0, r0_ready}, 32'd1);
      chk("pst_we",    {31'd0, mem_write_en}, 32'd0);
      step; req0(1'b0, 32'h10, 32'h0, 4'h0);
      settle;
      chk("rmwrd_ready", {31'd0, r0_ready}, 32'd0);
      chk("rmwrd_we",    {31'd0, mem_write_en}, 32'd0);
      chk("rmwrd_raddr", mem_read_addr, 32'd4);
      chk("rmwrd_rsp",   {31'd0, r0_rsp_valid}, 32'd0);
      step;
      settle;
      chk("rmwwr_ready", {31'd0, r0_ready}, 32'd0);
      chk("rmwwr_we",    {31'd0, mem_write_en}, 32'd1);
      chk("rmwwr_waddr", mem_write_addr, 32'd4);
      chk("rmwwr_wdata", mem_write_data, 32'hDEADBEAB);
      step;
      settle;
      chk("pst_rsp",        {31'd0, r0_rsp_valid}, 32'd1);
      chk("pst_rdata_keep", r0_rdata, 32'hDEADBEEF);
      chk("rb_ready",       {31'd0, r0_ready}, 32'd1);
      step; idle_all;
      settle;
      chk("rb_rsp",   {31'd0, r0_rsp_valid}, 32'd1);
      chk("rb_rdata", r0_rdata, 32'hDEADBEAB);

      store0(32'h10, 32'hDEADBEEF);
      store0(32'h20, 32'h11111111);
      store0(32'h30, 32'h22222222);

      // be=0 store from r1: no write, still responds
      step; req1(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
      settle;
      chk("be0_ready", {31'd0, r1_ready}, 32'd1);
      chk("be0_we",    {31'd0, mem_write_en}, 32'd0);
      step; idle_all;
      settle;
      chk("be0_rsp", {31'd0, r1_rsp_valid}, 32'd1);

      // both requesters loading continuously; last grant was r1
      step; req0(1'b0, 32'h20, 32'h0, 4'h0); req1(1'b0, 32'h30, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         settle;
`ifdef DMEM_ARB_RR_EN
         exp0 = (i % 2 == 0);
`else
         exp0 = 1'b1;
`endif
         chk("arb_r0_ready", {31'd0, r0_ready}, {31'd0, exp0});
         chk("arb_r1_ready", {31'd0, r1_ready}, {31'd0, ~exp0});
         step;
      end
      idle_all;
      settle;
      chk("arb_r0_rdata", r0_rdata, 32'h11111111);
`ifdef DMEM_ARB_RR_EN
      chk("arb_r1_rdata", r1_rdata, 32'h22222222);
`else
      chk("arb_r1_rdata", r1_rdata, 32'h00000000);
`endif

      // reset while in RMW_RD aborts the store
      step; req0(1'b1, 32'h10, 32'h00001200, 4'b0010);
      settle;
      chk("abort_ready", {31'd0, r0_ready}, 32'd1);
      step;
      wr_snap = wr_cnt;
      rst_n = 1'b0;
      idle_all;
      settle;
      chk("abort_we", {31'd0, mem_write_en}, 32'd0);
      step;
      settle;
      chk("abort_rsp",   {31'd0, r0_rsp_valid}, 32'd0);
      chk("abort_wrcnt", 32'(wr_cnt), 32'(wr_snap));
      rst_n = 1'b1;
      step; req0(1'b0, 32'h10, 32'h0, 4'h0);
      step; idle_all;
      settle;
      chk("abort_word", r0_rdata, 32'hDEADBEEF);

      // address aliasing modulo 16 KB
      step; req1(1'b1, 32'h00004010, 32'hCAFEF00D, 4'hF);
      settle;
      chk("alias_waddr", mem_write_addr, 32'd4);
      step; idle_all; req0(1'b0, 32'h10, 32'h0, 4'h0);
      settle;
      chk("alias_st_rsp", {31'd0, r1_rsp_valid}, 32'd1);
      step; idle_all;
      settle;
      chk("alias_rdata", r0_rdata, 32'hCAFEF00D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
